// File: rtl/seq_detect_0110_moore.sv
// Moore FSM detecting the serial pattern 0-1-1-0 with a saturating match counter.
// Define SEQ_DETECT_OVERLAP_EN to reuse the trailing 0 of a match (overlapping mode).
module seq_detect_0110_moore #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    // Next-state decode from the current progress and the incoming bit
    always_comb begin
        w_next = S0;
        unique case (r_state)
            S0: w_next = in ? S0 : S1;
            S1: w_next = in ? S2 : S1;
            S2: w_next = in ? S3 : S1;
            S3: w_next = in ? S0 : S4;
`ifdef SEQ_DETECT_OVERLAP_EN
            S4: w_next = in ? S2 : S1;
`else
            S4: w_next = in ? S0 : S1;
`endif
            default: w_next = S0;
        endcase
    end

    assign w_hit = (w_next == S4);

    // State, registered match flag and saturating match counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S0;
            r_out   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= w_hit;
            if (w_hit && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out         = r_out;
    assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detect_0110_moore.sv
// Directed table-driven bench for seq_detect_0110_moore.
// Two instances: default counter width and a 2-bit counter for saturation.
module tb_seq_detect_0110_moore;

    typedef struct {
        bit       rst_n;
        bit       din;
        bit       exp_out;
        int       exp_cnt;
        int       exp_cnt_s;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       out_a;
    logic [7:0] cnt_a;
    logic       out_b;
    logic [1:0] cnt_b;

    int checks;
    int errors;
    vec_t tbl[$];

    seq_detect_0110_moore #(.CNT_W(8)) u_dut_a (
        .clk         (clk),
        .reset       (rst_n),
        .in          (din),
        .out         (out_a),
        .match_count (cnt_a)
    );

    seq_detect_0110_moore #(.CNT_W(2)) u_dut_b (
        .clk         (clk),
        .reset       (rst_n),
        .in          (din),
        .out         (out_b),
        .match_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void add(input bit r, input bit d,
                                input bit o, input int c);
        vec_t v;
        v.rst_n     = r;
        v.din       = d;
        v.exp_out   = o;
        v.exp_cnt   = c;
        v.exp_cnt_s = (c > 3) ? 3 : c;
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n = v.rst_n;
        din   = v.din;
        @(posedge clk);
        #1;
        chk($sformatf("out[%0d]", idx), int'(out_a), int'(v.exp_out));
        chk($sformatf("cnt[%0d]", idx), int'(cnt_a), v.exp_cnt);
        chk($sformatf("out_s[%0d]", idx), int'(out_b), int'(v.exp_out));
        chk($sformatf("cnt_s[%0d]", idx), int'(cnt_b), v.exp_cnt_s);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        din    = 1'b0;

        // basic 0110 then a 1
        add(0, 0, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 1, 1);
        add(1, 1, 0, 1);

        // 0110110: overlap depends on build
        add(0, 0, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 1, 1);
        add(1, 1, 0, 1);
        add(1, 1, 0, 1);
`ifdef SEQ_DETECT_OVERLAP_EN
        add(1, 0, 1, 2);
        add(1, 0, 0, 2);
`else
        add(1, 0, 0, 1);
        add(1, 0, 0, 1);
`endif

        // 0100110: broken prefix
        add(0, 0, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 1, 1);
        add(1, 1, 0, 1);

        // five back-to-back 0110: saturation on the narrow counter
        add(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 0, k);
            add(1, 1, 0, k);
            add(1, 1, 0, k);
            add(1, 0, 1, k + 1);
        end
        add(1, 1, 0, 5);

        // twenty 1s then twenty 0s
        add(0, 0, 0, 0);
        for (int k = 0; k < 20; k++) add(1, 1, 0, 0);
        for (int k = 0; k < 20; k++) add(1, 0, 0, 0);

        #2;
        chk("rst_out", int'(out_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_cnt_s", int'(cnt_b), 0);

        foreach (tbl[i]) apply(tbl[i], i);

        // reset mid-cycle while out is high
        tbl.delete();
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 1, 1);
        foreach (tbl[i]) apply(tbl[i], 100 + i);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out", int'(out_a), 0);
        chk("async_cnt", int'(cnt_a), 0);

        // stream 011, reset mid-cycle for 2 cycles, release with 0
        tbl.delete();
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        foreach (tbl[i]) apply(tbl[i], 200 + i);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out", int'(out_a), 0);
        chk("mid_cnt", int'(cnt_a), 0);
        tbl.delete();
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        add(1, 0, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 1, 1);
        foreach (tbl[i]) apply(tbl[i], 300 + i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
